// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the control unit and its program counter:
//     - state_e  : controller state encoding (also exported on state_out)
//     - opcode_e : instruction opcodes
//     - ALU_*    : ALU operation select codes
//     - field positions inside the 16-bit instruction word
//     - ctrl_t   : bundle of all registered control outputs
//     - exec_state / ctrl_for : decode helpers used by the FSM
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int IR_W = 16;
  localparam int PC_W = 7;

  // Instruction field positions.
  localparam int OPC_HI   = 15;
  localparam int OPC_LO   = 12;
  localparam int F1_HI    = 11;  // Ra (ADD/SUB/STORE) or Rd (LOAD)
  localparam int F1_LO    = 8;
  localparam int F2_HI    = 7;   // Rb (ADD/SUB)
  localparam int F2_LO    = 4;
  localparam int F3_HI    = 3;   // Rd (ADD/SUB)
  localparam int F3_LO    = 0;
  localparam int DADDR_HI = 7;   // data memory address (LOAD/STORE)
  localparam int DADDR_LO = 0;

  // ALU operation select codes.
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_e;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'b0000,
    OP_STORE = 4'b0001,
    OP_LOAD  = 4'b0010,
    OP_ADD   = 4'b0011,
    OP_SUB   = 4'b0100,
    OP_HALT  = 4'b0101
  } opcode_e;

  // All controller outputs, registered together so they always agree with
  // the state they belong to.
  typedef struct packed {
    logic [7:0] d_addr;
    logic       d_wr;
    logic       rf_s;
    logic [4:0] rf_w_addr;
    logic [4:0] rf_ra_addr;
    logic [4:0] rf_rb_addr;
    logic       rf_w_en;
    logic [2:0] alu_s0;
    logic       halted;
  } ctrl_t;

  // Execute state selected by the opcode of a latched instruction.
  // Unassigned opcodes fall through to NOOP.
  function automatic state_e exec_state(input logic [IR_W-1:0] ir);
    state_e s;
    case (ir[OPC_HI:OPC_LO])
      OP_NOOP:  s = S_NOOP;
      OP_STORE: s = S_STORE;
      OP_LOAD:  s = S_LOAD_A;
      OP_ADD:   s = S_ADD;
      OP_SUB:   s = S_SUB;
      OP_HALT:  s = S_HALT;
      default:  s = S_NOOP;
    endcase
    return s;
  endfunction

  // Output values for a given state and latched instruction. Register
  // fields are 4 bits in the instruction and zero-extended to 5-bit
  // register file addresses. Anything not driven by a state stays 0.
  function automatic ctrl_t ctrl_for(input state_e st, input logic [IR_W-1:0] ir);
    ctrl_t c;
    c = '0;
    case (st)
      S_LOAD_A: begin
        c.d_addr = ir[DADDR_HI:DADDR_LO];
        c.rf_s   = 1'b1;
      end
      S_LOAD_B: begin
        c.d_addr    = ir[DADDR_HI:DADDR_LO];
        c.rf_s      = 1'b1;
        c.rf_w_en   = 1'b1;
        c.rf_w_addr = {1'b0, ir[F1_HI:F1_LO]};
      end
      S_STORE: begin
        c.d_addr     = ir[DADDR_HI:DADDR_LO];
        c.rf_ra_addr = {1'b0, ir[F1_HI:F1_LO]};
        c.d_wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        c.rf_ra_addr = {1'b0, ir[F1_HI:F1_LO]};
        c.rf_rb_addr = {1'b0, ir[F2_HI:F2_LO]};
        c.rf_w_addr  = {1'b0, ir[F3_HI:F3_LO]};
        c.rf_s       = 1'b0;
        c.rf_w_en    = 1'b1;
        c.alu_s0     = (st == S_ADD) ? ALU_ADD : ALU_SUB;
      end
      S_HALT: begin
        c.halted = 1'b1;
        c.alu_s0 = ALU_PASS;
      end
      default: begin
        c.alu_s0 = ALU_PASS;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/program_counter.sv
// -----------------------------------------------------------------------------
// program_counter
//   W-bit instruction address register. Wraps naturally from 2^W-1 to 0.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low reset (pc -> 0)
//     clr   : synchronous clear (wins over inc)
//     inc   : increment by one at the next rising edge
//     pc    : current program counter value
// -----------------------------------------------------------------------------
module program_counter #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (clr) begin
      pc <= '0;
    end else if (inc) begin
      pc <= pc + W'(1);
    end
  end

endmodule

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//   Multi-cycle controller for a small 16-bit instruction set. Fetches an
//   instruction, decodes it, then drives register file / data memory / ALU
//   controls for one execute cycle (two for LOAD).
//   Ports:
//     clk, rst_n  : clock (rising edge) and async active-low reset
//     IR_data     : instruction word at PC_addr, sampled in FETCH
//     PC_addr     : instruction memory address (current PC)
//     D_addr      : data memory address
//     D_wr        : data memory write enable
//     RF_s        : register write-data select (1 = memory, 0 = ALU)
//     RF_W_addr   : register file write address
//     RF_Ra_addr  : register file read port A address
//     RF_Rb_addr  : register file read port B address
//     RF_W_en     : register file write enable
//     ALU_s0      : ALU op (000 pass A, 001 add, 010 subtract)
//     Halted      : high while in HALT
//     state_out   : current state encoding (debug)
//
//   All control outputs are registered together with the state: at each
//   edge the FSM picks its next state and loads the outputs that belong to
//   that state, so nothing reaches the outputs combinationally from IR_data.
// -----------------------------------------------------------------------------
module control_unit
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IR_W-1:0] IR_data,
  output logic [PC_W-1:0] PC_addr,
  output logic [7:0]      D_addr,
  output logic            D_wr,
  output logic            RF_s,
  output logic [4:0]      RF_W_addr,
  output logic [4:0]      RF_Ra_addr,
  output logic [4:0]      RF_Rb_addr,
  output logic            RF_W_en,
  output logic [2:0]      ALU_s0,
  output logic            Halted,
  output logic [3:0]      state_out
);

  state_e          state;
  logic [IR_W-1:0] ir;
  ctrl_t           ctrl;
  logic            pc_inc;
  logic            pc_clr;
  logic [PC_W-1:0] pc;

  // The PC advances on the same edge that latches IR in FETCH.
  assign pc_inc = (state == S_FETCH);
  assign pc_clr = (state == S_INIT);

  program_counter #(.W(PC_W)) u_pc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (pc_clr),
    .inc   (pc_inc),
    .pc    (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
      ir    <= '0;
      ctrl  <= '0;
    end else begin
      case (state)
        S_INIT: begin
          state <= S_FETCH;
          ctrl  <= ctrl_for(S_FETCH, ir);
        end
        S_FETCH: begin
          ir    <= IR_data;
          state <= S_DECODE;
          ctrl  <= ctrl_for(S_DECODE, ir);
        end
        S_DECODE: begin
          // ir already holds the fetched word here, so the execute-state
          // outputs are built from the latched instruction.
          state <= exec_state(ir);
          ctrl  <= ctrl_for(exec_state(ir), ir);
        end
        S_LOAD_A: begin
          state <= S_LOAD_B;
          ctrl  <= ctrl_for(S_LOAD_B, ir);
        end
        S_NOOP, S_LOAD_B, S_STORE, S_ADD, S_SUB: begin
          state <= S_FETCH;
          ctrl  <= ctrl_for(S_FETCH, ir);
        end
        S_HALT: begin
          state <= S_HALT;
          ctrl  <= ctrl_for(S_HALT, ir);
        end
        default: begin
          state <= S_INIT;
          ctrl  <= '0;
        end
      endcase
    end
  end

  assign PC_addr    = pc;
  assign D_addr     = ctrl.d_addr;
  assign D_wr       = ctrl.d_wr;
  assign RF_s       = ctrl.rf_s;
  assign RF_W_addr  = ctrl.rf_w_addr;
  assign RF_Ra_addr = ctrl.rf_ra_addr;
  assign RF_Rb_addr = ctrl.rf_rb_addr;
  assign RF_W_en    = ctrl.rf_w_en;
  assign ALU_s0     = ctrl.alu_s0;
  assign Halted     = ctrl.halted;
  assign state_out  = state;

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
//   Self-checking bench for control_unit. An instruction memory array feeds
//   IR_data from PC_addr. Expected per-cycle outputs come from an
//   instruction-level model that expands each instruction into its cycle
//   sequence (FETCH, DECODE, execute cycles) and pushes them onto exp_q.
// -----------------------------------------------------------------------------
module tb_control_unit;
  import cpu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [15:0] ir_data;
  logic [6:0]  pc_addr;
  logic [7:0]  d_addr;
  logic        d_wr;
  logic        rf_s;
  logic [4:0]  rf_w_addr;
  logic [4:0]  rf_ra_addr;
  logic [4:0]  rf_rb_addr;
  logic        rf_w_en;
  logic [2:0]  alu_s0;
  logic        halted;
  logic [3:0]  state_out;

  logic [15:0] imem [128];
  assign ir_data = imem[pc_addr];

  control_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .IR_data    (ir_data),
    .PC_addr    (pc_addr),
    .D_addr     (d_addr),
    .D_wr       (d_wr),
    .RF_s       (rf_s),
    .RF_W_addr  (rf_w_addr),
    .RF_Ra_addr (rf_ra_addr),
    .RF_Rb_addr (rf_rb_addr),
    .RF_W_en    (rf_w_en),
    .ALU_s0     (alu_s0),
    .Halted     (halted),
    .state_out  (state_out)
  );

  // ---------------- observation record / scoreboard ----------------
  typedef struct packed {
    logic [3:0] st;
    logic [6:0] pc;
    logic [7:0] d_addr;
    logic       d_wr;
    logic       rf_s;
    logic [4:0] w_addr;
    logic [4:0] ra;
    logic [4:0] rb;
    logic       w_en;
    logic [2:0] alu;
    logic       halted;
  } obs_t;

  localparam int OBS_W = $bits(obs_t);

  logic [OBS_W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  function automatic obs_t mk(input state_e s, input int pc);
    obs_t e;
    e    = '0;
    e.st = s;
    e.pc = 7'(pc);
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t a;
    a.st     = state_out;
    a.pc     = pc_addr;
    a.d_addr = d_addr;
    a.d_wr   = d_wr;
    a.rf_s   = rf_s;
    a.w_addr = rf_w_addr;
    a.ra     = rf_ra_addr;
    a.rb     = rf_rb_addr;
    a.w_en   = rf_w_en;
    a.alu    = alu_s0;
    a.halted = halted;
    return a;
  endfunction

  // Strobes, state, PC and Halted are always checked; address / select
  // fields only in the states that define them.
  function automatic obs_t care(input obs_t e);
    obs_t m;
    m        = '0;
    m.st     = '1;
    m.pc     = '1;
    m.d_wr   = 1'b1;
    m.w_en   = 1'b1;
    m.alu    = '1;
    m.halted = 1'b1;
    if (e.st inside {S_LOAD_A, S_LOAD_B, S_STORE}) m.d_addr = '1;
    if (e.st inside {S_LOAD_A, S_LOAD_B, S_ADD, S_SUB}) m.rf_s = 1'b1;
    if (e.st inside {S_LOAD_B, S_ADD, S_SUB}) m.w_addr = '1;
    if (e.st inside {S_STORE, S_ADD, S_SUB}) m.ra = '1;
    if (e.st inside {S_ADD, S_SUB}) m.rb = '1;
    return m;
  endfunction

  task automatic check(input string name, input obs_t e);
    obs_t a;
    obs_t m;
    a = sample();
    m = care(e);
    checks++;
    if ((a & m) !== (e & m)) begin
      failures++;
      $display("FAIL %s: got st=%0d pc=%0d fields=%h, want st=%0d pc=%0d fields=%h (mask %h)",
               name, a.st, a.pc, a, e.st, e.pc, e, m);
    end
  endtask

  // ---------------- reference model ----------------
  // Walks the program from PC 0 at instruction granularity and lists the
  // outputs of every cycle, starting with the INIT cycle after reset.
  task automatic build_expected(input int n);
    obs_t        e;
    int          pc;
    logic [15:0] w;
    exp_q.delete();
    pc = 0;
    exp_q.push_back(mk(S_INIT, 0));
    while (exp_q.size() < n) begin
      w = imem[pc];
      exp_q.push_back(mk(S_FETCH, pc));
      pc = (pc + 1) % 128;
      exp_q.push_back(mk(S_DECODE, pc));
      case (w[15:12])
        4'd1: begin
          e        = mk(S_STORE, pc);
          e.d_wr   = 1'b1;
          e.d_addr = w[7:0];
          e.ra     = {1'b0, w[11:8]};
          exp_q.push_back(e);
        end
        4'd2: begin
          e        = mk(S_LOAD_A, pc);
          e.d_addr = w[7:0];
          e.rf_s   = 1'b1;
          exp_q.push_back(e);
          e.st     = S_LOAD_B;
          e.w_en   = 1'b1;
          e.w_addr = {1'b0, w[11:8]};
          exp_q.push_back(e);
        end
        4'd3, 4'd4: begin
          e        = mk((w[15:12] == 4'd3) ? S_ADD : S_SUB, pc);
          e.ra     = {1'b0, w[11:8]};
          e.rb     = {1'b0, w[7:4]};
          e.w_addr = {1'b0, w[3:0]};
          e.w_en   = 1'b1;
          e.rf_s   = 1'b0;
          e.alu    = (w[15:12] == 4'd3) ? 3'b001 : 3'b010;
          exp_q.push_back(e);
        end
        4'd5: begin
          e        = mk(S_HALT, pc);
          e.halted = 1'b1;
          while (exp_q.size() < n) exp_q.push_back(e);
        end
        default: exp_q.push_back(mk(S_NOOP, pc));
      endcase
    end
    while (exp_q.size() > n) void'(exp_q.pop_back());
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_imem();
    for (int a = 0; a < 128; a++) imem[a] = 16'h0000;
  endtask

  // Expects rst_n low; releases it and compares n cycles against the model.
  task automatic run_checked(input string name, input int n);
    obs_t e;
    build_expected(n);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      e = exp_q.pop_front();
      check($sformatf("%s[%0d]", name, i), e);
    end
  endtask

  // ---------------- vector table ----------------
  // Each entry: instruction at address 0 and the expected outputs of its
  // first execute cycle (PC already advanced to 1).
  typedef struct {
    logic [15:0] ir;
    obs_t        exp;
  } vec_t;

  localparam int NV = 10;
  vec_t tbl [NV];

  task automatic fill_table();
    obs_t e;
    tbl[0].ir = 16'h0000; tbl[0].exp = mk(S_NOOP, 1);
    e = mk(S_LOAD_A, 1); e.d_addr = 8'hA5; e.rf_s = 1'b1;
    tbl[1].ir = 16'h21A5; tbl[1].exp = e;
    e = mk(S_ADD, 1); e.ra = 5'd1; e.rb = 5'd2; e.w_addr = 5'd3; e.alu = 3'b001; e.w_en = 1'b1;
    tbl[2].ir = 16'h3123; tbl[2].exp = e;
    e.st = S_SUB; e.alu = 3'b010;
    tbl[3].ir = 16'h4123; tbl[3].exp = e;
    e = mk(S_STORE, 1); e.d_wr = 1'b1; e.d_addr = 8'h10; e.ra = 5'd3;
    tbl[4].ir = 16'h1310; tbl[4].exp = e;
    e = mk(S_HALT, 1); e.halted = 1'b1;
    tbl[5].ir = 16'h5000; tbl[5].exp = e;
    tbl[6].ir = 16'hF000; tbl[6].exp = mk(S_NOOP, 1);
    e = mk(S_ADD, 1); e.ra = 5'd5; e.rb = 5'd5; e.w_addr = 5'd5; e.alu = 3'b001; e.w_en = 1'b1;
    tbl[7].ir = 16'h3555; tbl[7].exp = e;
    e = mk(S_LOAD_A, 1); e.d_addr = 8'h00; e.rf_s = 1'b1;
    tbl[8].ir = 16'h2F00; tbl[8].exp = e;
    e = mk(S_SUB, 1); e.ra = 5'd15; e.rb = 5'd0; e.w_addr = 5'd15; e.alu = 3'b010; e.w_en = 1'b1;
    tbl[9].ir = 16'h4F0F; tbl[9].exp = e;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    obs_t e;
    int   k;
    logic [3:0] op;

    rst_n = 1'b0;
    clear_imem();
    fill_table();
    do_reset();

    // Reset state.
    check("reset_state", mk(S_INIT, 0));

    // Reset release with all-zero memory: INIT, FETCH, DECODE, NOOP, FETCH pc=1.
    run_checked("noop_seq", 6);

    // Table-driven execute-cycle checks.
    for (int i = 0; i < NV; i++) begin
      clear_imem();
      imem[0] = tbl[i].ir;
      do_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check($sformatf("vec%0d_%h", i, tbl[i].ir), tbl[i].exp);
    end

    // LOAD second cycle, then back to FETCH at pc 1.
    clear_imem();
    imem[0] = 16'h21A5;
    do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    e = mk(S_LOAD_B, 1); e.d_addr = 8'hA5; e.rf_s = 1'b1; e.w_en = 1'b1; e.w_addr = 5'd1;
    check("load_b", e);
    @(negedge clk);
    #1;
    check("load_then_fetch", mk(S_FETCH, 1));

    // HALT holds state and PC; reset out of HALT goes straight to INIT.
    clear_imem();
    imem[0] = 16'h5000;
    do_reset();
    run_checked("halt", 30);
    rst_n = 1'b0;
    #1;
    check("halt_reset", mk(S_INIT, 0));
    repeat (2) @(negedge clk);

    // Reset pulse during LOAD_A aborts the load with no write strobe.
    clear_imem();
    imem[0] = 16'h21A5;
    do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    while (k < 10 && state_out != 4'(S_LOAD_A)) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (state_out != 4'(S_LOAD_A)) begin
      failures++;
      $display("FAIL reach_load_a: state=%0d after %0d cycles, want %0d", state_out, k, S_LOAD_A);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_in_load_a", mk(S_INIT, 0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("rst_hold[%0d]", i), mk(S_INIT, 0));
    end
    run_checked("after_rst", 12);

    // PC wrap over 128 NOOPs.
    clear_imem();
    do_reset();
    run_checked("wrap", 3 * 128 + 6);

    // Random programs (no HALT so the whole run stays busy).
    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < 128; a++) begin
        op = 4'($urandom_range(0, 14));
        if (op >= 4'd5) op = op + 4'd1;
        imem[a] = {op, 12'($urandom_range(0, 4095))};
      end
      do_reset();
      run_checked($sformatf("rand%0d", r), 300);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: IR_data  input  16  instruction word from instruction memory; valid during FETCH for the current PC_addr.
REQ-004 SHALL have port: PC_addr  output  7  instruction memory address (current PC).
REQ-005 SHALL have port: D_addr  output  8  data memory address.
REQ-006 SHALL have port: D_wr  output  1  data memory write enable.
REQ-007 SHALL have port: RF_s  output  1  register file write-data select: 1 = data memory, 0 = ALU result.
REQ-008 SHALL have ports: RF_W_addr, RF_Ra_addr, RF_Rb_addr  output  5 each  register file write and read addresses.
REQ-009 SHALL have port: RF_W_en  output  1  register file write enable.
REQ-010 SHALL have port: ALU_s0  output  3  ALU operation select: 000 pass A, 001 add, 010 subtract.
REQ-011 SHALL have ports: Halted  output  1  high in HALT; state_out  output  4  current state encoding, for debug.

Function
REQ-012 SHALL decode the instruction fields: opcode IR[15:12]. ADD/SUB: Ra IR[11:8], Rb IR[7:4], Rd IR[3:0]. LOAD: Rd IR[11:8], daddr IR[7:0]. STORE: Ra IR[11:8], daddr IR[7:0].
REQ-013 SHALL use the opcodes NOOP 0000, STORE 0001, LOAD 0010, ADD 0011, SUB 0100, HALT 0101; every other opcode SHALL execute as NOOP.
REQ-014 SHALL zero-extend the 4-bit register fields to 5-bit addresses (upper bit always 0).
REQ-015 SHALL implement the states INIT, FETCH, DECODE, NOOP, LOAD_A, LOAD_B, STORE, ADD, SUB, HALT.
REQ-016 SHALL follow these transitions: INIT -> FETCH; FETCH -> DECODE; DECODE -> the execute state selected by the opcode; NOOP/LOAD_B/STORE/ADD/SUB -> FETCH; LOAD_A -> LOAD_B; HALT -> HALT until reset.
REQ-017 FETCH SHALL load IR from IR_data and increment the PC at the same clock edge.
REQ-018 PC SHALL wrap from 127 to 0 without halting.
REQ-019 Instruction latency SHALL be: NOOP, ADD, SUB and STORE take 3 cycles FETCH-to-FETCH; LOAD takes 4.
REQ-020 LOAD_A SHALL drive D_addr = daddr and RF_s = 1 with RF_W_en = 0. LOAD_B SHALL hold these and also drive RF_W_en = 1 and RF_W_addr = Rd.
REQ-021 STORE SHALL drive D_addr = daddr, RF_Ra_addr = Ra and D_wr = 1 for exactly one cycle.
REQ-022 ADD and SUB SHALL each, for one cycle, drive RF_Ra_addr = Ra, RF_Rb_addr = Rb, RF_s = 0, RF_W_en = 1 and RF_W_addr = Rd, with ALU_s0 = 001 for ADD and 010 for SUB.
REQ-023 In all states not named in REQ-020..022, RF_W_en and D_wr SHALL be 0 and ALU_s0 SHALL be 000.
REQ-024 Outputs SHALL be Moore outputs decoded from the state and IR only, with no combinational path from IR_data.
REQ-025 An instruction with Rd = Ra or Rd = Rb SHALL be legal; the write lands at the end of the execute cycle.

Reset
REQ-026 On rst_n = 0 the block SHALL immediately enter INIT, clear PC and IR to 0, and deassert D_wr, RF_W_en and Halted.
REQ-027 Reset asserted in any state (including mid-LOAD and in HALT) SHALL abort the instruction with no further write strobe.
REQ-028 After rst_n rises, the first FETCH SHALL occur one cycle later, at PC 0.

Structure
REQ-029 Shared package cpu_pkg SHALL hold the state enum, the opcode enum, the ALU select constants and the field-position constants.
REQ-030 The PC SHALL be a separate sub-module program_counter with synchronous clear, increment and asynchronous active-low reset.

Verification
REQ-031 Reset release with IR_data = 0x0000 SHALL give INIT -> FETCH -> DECODE -> NOOP -> FETCH, with PC_addr = 1 at the second FETCH and no write strobes.
REQ-032 LOAD 0x21A5 SHALL give LOAD_A with D_addr = 0xA5 and RF_W_en = 0, then LOAD_B with RF_s = 1, RF_W_en = 1 and RF_W_addr = 1.
REQ-033 ADD 0x3123 SHALL give one cycle with Ra = 1, Rb = 2, RF_W_addr = 3, ALU_s0 = 001 and RF_W_en = 1; SUB 0x4123 SHALL give the same with ALU_s0 = 010.
REQ-034 STORE 0x1310 SHALL give one cycle with D_wr = 1, D_addr = 0x10 and RF_Ra_addr = 3.
REQ-035 HALT 0x5000 SHALL assert Halted and hold PC constant for at least 20 cycles; illegal opcode 0xF000 SHALL behave as NOOP.
REQ-036 rst_n pulsed low during LOAD_A SHALL give INIT immediately with PC = 0 and no RF_W_en pulse; 128 NOOPs SHALL wrap PC_addr from 127 to 0.
